wb16_arbiter: RTL and testbench

WB16_ARBITER -- requirements
Module: wb16_arbiter

---
 rtl/wb16_pkg.sv | 24 ++
 rtl/wb16_timeout_cnt.sv | 34 +++
 rtl/wb16_arbiter.sv | 170 +++++++++++++++++
 tb/tb_wb16_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb16_pkg.sv
// Shared types and widths for the two-master wb16 arbiter in front of the I2C master register port.
package wb16_pkg;

    localparam int WB16_ADR_W = 3;
    localparam int WB16_DAT_W = 16;
    localparam int WB16_SEL_W = 2;
    localparam int WB16_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        ABORT = 2'd3
    } wb16_state_e;

    function automatic logic [1:0] wb16_grant(input wb16_state_e st);
        logic [1:0] g;
        g = 2'b00;
        if (st == OWN0) g = 2'b01;
        if (st == OWN1) g = 2'b10;
        return g;
    endfunction

endpackage

// File: rtl/wb16_timeout_cnt.sv
// Slave stall timer: counts cycles with stb high and no ack, flags the cycle the limit is reached.
module wb16_timeout_cnt
    import wb16_pkg::*;
#(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stb_i,
    input  logic ack_i,
    output logic timeout_o
);

    localparam logic [WB16_CNT_W-1:0] LAST = WB16_CNT_W'(LIMIT - 1);

    logic [WB16_CNT_W-1:0] cnt_q, cnt_d;
    logic                  stall;

    assign stall     = stb_i & ~ack_i;
    // An ack in the limit cycle suppresses the timeout because stall is already low.
    assign timeout_o = stall && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!stall || timeout_o) cnt_d = '0;
        else                     cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/wb16_arbiter.sv
// Two-master Wishbone arbiter with bus lock, round-robin tie break and slave-stall abort.
//  state | meaning
//  IDLE  | no owner, slave port quiet, arbitrating
//  OWN0  | master 0 drives the slave port
//  OWN1  | master 1 drives the slave port
//  ABORT | slave timed out; err pulsed to owner, wait for its cyc to drop
module wb16_arbiter
    import wb16_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WB16_ADR_W-1:0] m0_adr_i,
    input  logic [WB16_DAT_W-1:0] m0_dat_i,
    input  logic [WB16_SEL_W-1:0] m0_sel_i,
    input  logic                  m0_we_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_cyc_i,
    output logic [WB16_DAT_W-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic [WB16_ADR_W-1:0] m1_adr_i,
    input  logic [WB16_DAT_W-1:0] m1_dat_i,
    input  logic [WB16_SEL_W-1:0] m1_sel_i,
    input  logic                  m1_we_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_cyc_i,
    output logic [WB16_DAT_W-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic [WB16_ADR_W-1:0] s_adr_o,
    output logic [WB16_DAT_W-1:0] s_dat_o,
    output logic [WB16_SEL_W-1:0] s_sel_o,
    output logic                  s_we_o,
    output logic                  s_stb_o,
    output logic                  s_cyc_o,
    input  logic [WB16_DAT_W-1:0] s_dat_i,
    input  logic                  s_ack_i,
    output logic [1:0]            grant_o
);

    logic [1:0]  rst_sync_q;
    logic        rst_n_sync;
    wb16_state_e state_q, state_d;
    logic [1:0]  grant_q;
    logic        last_grant_q, last_grant_d;
    logic        abort_owner_q, abort_owner_d;
    logic        abort_first_q;
    logic        timeout;

    // Assertion reaches every flop at once through the synchroniser clear; release is clocked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= 2'b00;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n_sync = rst_sync_q[1];

    wb16_timeout_cnt #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst_n    (rst_n_sync),
        .stb_i    (s_stb_o),
        .ack_i    (s_ack_i),
        .timeout_o(timeout)
    );

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        abort_owner_d = abort_owner_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) state_d = last_grant_q ? OWN0 : OWN1;
                else if (m0_cyc_i)        state_d = OWN0;
                else if (m1_cyc_i)        state_d = OWN1;
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b0;
                end else if (timeout) begin
                    state_d       = ABORT;
                    abort_owner_d = 1'b0;
                end
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b1;
                end else if (timeout) begin
                    state_d       = ABORT;
                    abort_owner_d = 1'b1;
                end
            end
            ABORT: begin
                if (abort_owner_q ? !m1_cyc_i : !m0_cyc_i) begin
                    state_d      = IDLE;
                    last_grant_d = abort_owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q       <= IDLE;
            grant_q       <= 2'b00;
            last_grant_q  <= 1'b1;
            abort_owner_q <= 1'b0;
            abort_first_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= wb16_grant(state_d);
            last_grant_q  <= last_grant_d;
            abort_owner_q <= abort_owner_d;
            abort_first_q <= (state_d == ABORT) && (state_q != ABORT);
        end
    end

    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        m0_dat_o = '0;
        m1_dat_o = '0;
        case (state_q)
            OWN0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_stb_o  = m0_stb_i;
                s_cyc_o  = m0_cyc_i;
                m0_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
                m1_dat_o = s_dat_i;
            end
            OWN1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_stb_o  = m1_stb_i;
                s_cyc_o  = m1_cyc_i;
                m1_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
                m1_dat_o = s_dat_i;
            end
            ABORT: begin
                m0_err_o = abort_first_q & ~abort_owner_q;
                m1_err_o = abort_first_q &  abort_owner_q;
            end
            default: ;
        endcase
    end

    assign grant_o = grant_q;

endmodule

// File: tb/tb_wb16_arbiter.sv
// Randomized and directed bench for wb16_arbiter against a transaction-level ownership model.
module tb_wb16_arbiter;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  m_adr [2];
    logic [15:0] m_dat [2];
    logic [1:0]  m_sel [2];
    logic        m_we  [2];
    logic        m_stb [2];
    logic        m_cyc [2];
    logic [15:0] m_dat_o [2];
    logic        m_ack_o [2];
    logic        m_err_o [2];
    logic [2:0]  s_adr_o;
    logic [15:0] s_dat_o;
    logic [1:0]  s_sel_o;
    logic        s_we_o, s_stb_o, s_cyc_o;
    logic [15:0] s_dat_i;
    logic        s_ack_i;
    logic [1:0]  grant_o;

    int n_chk = 0;
    int n_err = 0;

    // model: owner (-1 none), abort bookkeeping, stalled-cycle count, last owner
    int own, abt_own, wt, last;
    bit abt, abt_first;

    always #5 clk = ~clk;

    wb16_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]), .m0_we_i(m_we[0]),
        .m0_stb_i(m_stb[0]), .m0_cyc_i(m_cyc[0]),
        .m0_dat_o(m_dat_o[0]), .m0_ack_o(m_ack_o[0]), .m0_err_o(m_err_o[0]),
        .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]), .m1_we_i(m_we[1]),
        .m1_stb_i(m_stb[1]), .m1_cyc_i(m_cyc[1]),
        .m1_dat_o(m_dat_o[1]), .m1_ack_o(m_ack_o[1]), .m1_err_o(m_err_o[1]),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        own = -1; abt = 1'b0; abt_own = 0; abt_first = 1'b0; wt = 0; last = 1;
    endtask

    task automatic idle_inputs();
        for (int n = 0; n < 2; n++) begin
            m_adr[n] = '0; m_dat[n] = '0; m_sel[n] = '0;
            m_we[n] = 1'b0; m_stb[n] = 1'b0; m_cyc[n] = 1'b0;
        end
        s_ack_i = 1'b0;
        s_dat_i = 16'($urandom);
    endtask

    task automatic set_master(input int n, input bit cyc, input bit stb, input bit we,
                              input logic [2:0] adr, input logic [15:0] dat);
        m_cyc[n] = cyc; m_stb[n] = stb; m_we[n] = we;
        m_adr[n] = adr; m_dat[n] = dat; m_sel[n] = 2'b11;
    endtask

    task automatic check_outputs();
        bit on;
        int o;
        on = (own >= 0);
        o  = on ? own : 0;
        chk("grant", 32'(grant_o), (own == 0) ? 32'd1 : (own == 1) ? 32'd2 : 32'd0);
        chk("s_cyc", 32'(s_cyc_o), on ? 32'(m_cyc[o]) : 32'd0);
        chk("s_stb", 32'(s_stb_o), on ? 32'(m_stb[o]) : 32'd0);
        chk("s_we",  32'(s_we_o),  on ? 32'(m_we[o])  : 32'd0);
        chk("s_adr", 32'(s_adr_o), on ? 32'(m_adr[o]) : 32'd0);
        chk("s_sel", 32'(s_sel_o), on ? 32'(m_sel[o]) : 32'd0);
        chk("s_dat", 32'(s_dat_o), on ? 32'(m_dat[o]) : 32'd0);
        for (int n = 0; n < 2; n++) begin
            chk(n == 0 ? "m0_ack" : "m1_ack", 32'(m_ack_o[n]), 32'((own == n) && s_ack_i));
            chk(n == 0 ? "m0_err" : "m1_err", 32'(m_err_o[n]), 32'(abt && abt_first && (abt_own == n)));
            chk(n == 0 ? "m0_dat" : "m1_dat", 32'(m_dat_o[n]), on ? 32'(s_dat_i) : 32'd0);
        end
    endtask

    task automatic model_next();
        bit stall, to;
        if (own >= 0) begin
            stall = m_stb[own] && !s_ack_i;
            to    = stall && (wt == T - 1);
            wt    = stall ? wt + 1 : 0;
            if (!m_cyc[own]) begin
                last = own; own = -1;
            end else if (to) begin
                abt = 1'b1; abt_first = 1'b1; abt_own = own; own = -1;
            end
        end else if (abt) begin
            abt_first = 1'b0;
            if (!m_cyc[abt_own]) begin
                abt = 1'b0; last = abt_own;
            end
        end else begin
            wt = 0;
            if (m_cyc[0] && m_cyc[1]) own = (last == 1) ? 0 : 1;
            else if (m_cyc[0])        own = 0;
            else if (m_cyc[1])        own = 1;
        end
    endtask

    // Entered and left at a falling edge with the cycle's inputs already applied.
    task automatic cyc_step();
        #1;
        check_outputs();
        model_next();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) cyc_step();
    endtask

    initial begin
        int stb_n, err_n, ack_pct;
        rst = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_s_cyc", 32'(s_cyc_o), 32'd0);
        @(negedge clk);
        do_reset();

        // single-master write
        set_master(0, 1, 1, 1, 3'h2, 16'h00A5);
        cyc_step();
        #1;
        chk("t27_grant", 32'(grant_o), 32'h1);
        chk("t27_adr",   32'(s_adr_o), 32'h2);
        chk("t27_dat",   32'(s_dat_o), 32'h00A5);
        chk("t27_noack", 32'(m_ack_o[0]), 32'd0);
        s_ack_i = 1'b1;
        #1;
        chk("t27_ack", 32'(m_ack_o[0]), 32'd1);
        cyc_step();
        s_ack_i = 1'b0;
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        repeat (2) cyc_step();

        // simultaneous request after reset, mandatory dead cycle on hand-off
        do_reset();
        set_master(0, 1, 1, 0, 3'h1, 16'h1111);
        set_master(1, 1, 1, 0, 3'h4, 16'h2222);
        cyc_step();
        chk("t28_first", 32'(grant_o), 32'h1);
        cyc_step();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        cyc_step();
        chk("t28_dead", 32'(grant_o), 32'h0);
        cyc_step();
        chk("t28_second", 32'(grant_o), 32'h2);
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        repeat (2) cyc_step();

        // m1 locks the bus over three read beats while m0 waits
        set_master(1, 1, 1, 0, 3'h0, 16'h0);
        cyc_step();
        set_master(0, 1, 1, 1, 3'h7, 16'hBEEF);
        for (int b = 0; b < 3; b++) begin
            m_adr[1] = 3'(b);
            s_ack_i = 1'b0;
            cyc_step();
            s_ack_i = 1'b1;
            s_dat_i = 16'h5A00 + 16'(b);
            #1;
            chk("t29_lock", 32'(grant_o), 32'h2);
            chk("t29_m0ack", 32'(m_ack_o[0]), 32'd0);
            chk("t29_rdat", 32'(m_dat_o[1]), 32'h5A00 + 32'(b));
            cyc_step();
        end
        s_ack_i = 1'b0;
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        cyc_step();
        cyc_step();
        chk("t29_m0_after", 32'(grant_o), 32'h1);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        repeat (2) cyc_step();

        // slave never acks: abort after exactly T stalled strobes
        set_master(0, 1, 1, 1, 3'h3, 16'h1234);
        stb_n = 0; err_n = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (s_stb_o) stb_n++;
            if (m_err_o[0]) err_n++;
            cyc_step();
        end
        chk("t30_stb_cycles", 32'(stb_n), 32'd8);
        chk("t30_err_pulses", 32'(err_n), 32'd1);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        cyc_step();
        chk("t30_idle", 32'(grant_o), 32'h0);
        cyc_step();

        // ack in the limit cycle beats the timeout
        set_master(0, 1, 1, 0, 3'h5, 16'h0);
        repeat (8) cyc_step();
        s_ack_i = 1'b1;
        #1;
        chk("t31_ack", 32'(m_ack_o[0]), 32'd1);
        chk("t31_noerr", 32'(m_err_o[0]), 32'd0);
        cyc_step();
        s_ack_i = 1'b0;
        cyc_step();
        chk("t31_still_own", 32'(grant_o), 32'h1);

        // reset mid-beat
        s_dat_i = 16'hABCD;
        #2;
        rst = 1'b0;
        #1;
        s_ack_i = 1'b1;
        #1;
        chk("t31_rst_grant", 32'(grant_o), 32'h0);
        chk("t31_rst_cyc", 32'(s_cyc_o), 32'd0);
        chk("t31_rst_stb", 32'(s_stb_o), 32'd0);
        chk("t31_rst_adr", 32'(s_adr_o), 32'd0);
        chk("t31_rst_ack", 32'(m_ack_o[0]), 32'd0);
        chk("t31_rst_err", 32'(m_err_o[0]), 32'd0);
        chk("t31_rst_dat", 32'(m_dat_o[0]), 32'd0);
        @(negedge clk);
        do_reset();

        // randomized traffic
        ack_pct = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) ack_pct = (($urandom_range(0, 2)) == 0) ? 0 : 25 * int'($urandom_range(1, 2));
            for (int n = 0; n < 2; n++) begin
                if (m_cyc[n]) begin
                    if ($urandom_range(0, 7) == 0) m_cyc[n] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    m_cyc[n] = 1'b1;
                end
                m_stb[n] = m_cyc[n] && ($urandom_range(0, 15) != 0);
                m_adr[n] = 3'($urandom);
                m_dat[n] = 16'($urandom);
                m_sel[n] = 2'($urandom);
                m_we[n]  = 1'($urandom);
            end
            s_ack_i = ($urandom_range(0, 99) < ack_pct);
            s_dat_i = 16'($urandom);
            cyc_step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
